// File: rtl/full_adder_unit.sv
// Registered WIDTH-bit ripple-carry full adder with a valid strobe and one-cycle latency.
// Define FULL_ADDER_OVERFLOW_EN to add the registered signed-overflow output o_overflow.
module full_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_carry,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef FULL_ADDER_OVERFLOW_EN
  ,
  output logic             o_overflow
`endif
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;

  assign w_c[0] = i_carry;

  // One full-adder cell per bit; carries ripple LSB to MSB in a single cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign w_s[gi]   = i_x[gi] ^ i_y[gi] ^ w_c[gi];
      assign w_c[gi+1] = (i_x[gi] & i_y[gi]) | (w_c[gi] & (i_x[gi] ^ i_y[gi]));
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sum   <= w_s;
        r_carry <= w_c[WIDTH];
      end
    end
  end

  assign o_valid = r_valid;
  assign o_sum   = r_sum;
  assign o_carry = r_carry;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic r_overflow;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow <= 1'b0;
    end else if (i_valid) begin
      r_overflow <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign o_overflow = r_overflow;
`endif

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench for full_adder_unit: a WIDTH=1 and a WIDTH=8 instance share clock and reset.
module tb_full_adder_unit;

  logic       clk;
  logic       rst_n;

  logic       v1, x1, y1, c1;
  logic       ov1, os1, oc1;

  logic       v8, c8;
  logic [7:0] x8, y8;
  logic       ov8, oc8;
  logic [7:0] os8;

`ifdef FULL_ADDER_OVERFLOW_EN
  logic       of1, of8;
`endif

  int errors = 0;
  int checks = 0;

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_x(x1), .i_y(y1), .i_carry(c1),
    .o_valid(ov1), .o_sum(os1), .o_carry(oc1)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .o_overflow(of1)
`endif
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .i_x(x8), .i_y(y8), .i_carry(c8),
    .o_valid(ov8), .o_sum(os8), .o_carry(oc8)
`ifdef FULL_ADDER_OVERFLOW_EN
    , .o_overflow(of8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_w1 [8];

  initial begin
    exp_w1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    rst_n = 1'b0;
    v1 = 1'b0; x1 = 1'b0; y1 = 1'b0; c1 = 1'b0;
    v8 = 1'b0; x8 = 8'h00; y8 = 8'h00; c8 = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_w1_valid", 64'(ov1), 64'd0);
    chk("rst_w1_sum",   64'(os1), 64'd0);
    chk("rst_w1_carry", 64'(oc1), 64'd0);
    chk("rst_w8_valid", 64'(ov8), 64'd0);
    chk("rst_w8_sum",   64'(os8), 64'd0);
    chk("rst_w8_carry", 64'(oc8), 64'd0);
    rst_n = 1'b1;

    // WIDTH=1 truth table, one combination per cycle
    for (int i = 0; i < 8; i++) begin
      {x1, y1, c1} = 3'(i);
      v1 = 1'b1;
      tick();
      chk($sformatf("w1_tt%0d_cs", i), 64'({oc1, os1}), 64'(exp_w1[i]));
      chk($sformatf("w1_tt%0d_valid", i), 64'(ov1), 64'd1);
      $display("w1 x=%0d y=%0d c=%0d -> carry=%0d sum=%0d valid=%0d", x1, y1, c1, oc1, os1, ov1);
    end

    // Hold: capture 1+0+0, then idle with 1,1,1 and with X data
    {x1, y1, c1} = 3'b100; v1 = 1'b1;
    tick();
    chk("hold_cap_sum",   64'(os1), 64'd1);
    chk("hold_cap_carry", 64'(oc1), 64'd0);
    {x1, y1, c1} = 3'b111; v1 = 1'b0;
    tick();
    chk("hold_sum",   64'(os1), 64'd1);
    chk("hold_carry", 64'(oc1), 64'd0);
    chk("hold_valid", 64'(ov1), 64'd0);
    x1 = 1'bx; y1 = 1'bx; c1 = 1'bx;
    tick();
    chk("holdx_sum",   64'(os1), 64'd1);
    chk("holdx_carry", 64'(oc1), 64'd0);
    $display("w1 hold -> carry=%0d sum=%0d valid=%0d", oc1, os1, ov1);

    // Asynchronous reset between edges, with valid 1+1+1 applied during reset
    {x1, y1, c1} = 3'b111; v1 = 1'b1;
    tick();
    chk("pre_rst_cs", 64'({oc1, os1}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sum",   64'(os1), 64'd0);
    chk("async_rst_carry", 64'(oc1), 64'd0);
    chk("async_rst_valid", 64'(ov1), 64'd0);
    tick();
    chk("in_rst_cs",    64'({oc1, os1}), 64'd0);
    chk("in_rst_valid", 64'(ov1), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_cs",    64'({oc1, os1}), 64'd3);
    chk("post_rst_valid", 64'(ov1), 64'd1);
    $display("w1 reset release -> carry=%0d sum=%0d valid=%0d", oc1, os1, ov1);
    v1 = 1'b0;

    // WIDTH=8 wrap-around and signed overflow
    x8 = 8'hFF; y8 = 8'h00; c8 = 1'b1; v8 = 1'b1;
    tick();
    chk("w8_wrap_sum",   64'(os8), 64'h00);
    chk("w8_wrap_carry", 64'(oc8), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_wrap_ovf", 64'(of8), 64'd0);
`endif
    $display("w8 FF+00+1 -> sum=%02h carry=%0d", os8, oc8);
    x8 = 8'h7F; y8 = 8'h01; c8 = 1'b0;
    tick();
    chk("w8_ovf_sum",   64'(os8), 64'h80);
    chk("w8_ovf_carry", 64'(oc8), 64'd0);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_ovf_ovf", 64'(of8), 64'd1);
`endif
    $display("w8 7F+01+0 -> sum=%02h carry=%0d", os8, oc8);

    // Back-to-back stream
    x8 = 8'h12; y8 = 8'h34; c8 = 1'b0;
    tick();
    chk("w8_b2b0_sum",   64'(os8), 64'h46);
    chk("w8_b2b0_carry", 64'(oc8), 64'd0);
    chk("w8_b2b0_valid", 64'(ov8), 64'd1);
    x8 = 8'hF0; y8 = 8'h10; c8 = 1'b1;
    tick();
    chk("w8_b2b1_sum",   64'(os8), 64'h01);
    chk("w8_b2b1_carry", 64'(oc8), 64'd1);
    chk("w8_b2b1_valid", 64'(ov8), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
    chk("w8_b2b1_ovf", 64'(of8), 64'd0);
`endif
    $display("w8 F0+10+1 -> sum=%02h carry=%0d", os8, oc8);

    // Mid-stream reset pulse right after a valid capture
    x8 = 8'h12; y8 = 8'h34; c8 = 1'b0;
    tick();
    chk("w8_mid_cap_sum", 64'(os8), 64'h46);
    v8 = 1'b0;
    rst_n = 1'b0;
    #4 rst_n = 1'b1;
    tick();
    chk("w8_mid_valid", 64'(ov8), 64'd0);
    chk("w8_mid_sum",   64'(os8), 64'h00);
    chk("w8_mid_carry", 64'(oc8), 64'd0);
    $display("w8 mid-stream reset -> sum=%02h valid=%0d", os8, ov8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
